// File: rtl/seg_display_scan_ctrl.sv
// Bus-mapped, time-multiplexed N-digit common-anode 7-segment controller.
// Provides prescaled scanning, per-digit blank/DP/blink masks, raw mode and PWM brightness.
module seg_display_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE_SHIFT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            Address,
    input  logic [7:0]            Data_Bus_in,
    output logic [7:0]            Data_Bus_out,
    input  logic                  Cen,
    input  logic                  Rd,
    input  logic                  Wr,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [NUM_DIGITS-1:0] anode
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT_W = 8 + PRESCALE_SHIFT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Active-low hex glyphs, segment order A..G from bit 6 down to bit 0.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'h01;
            4'h1:    g = 7'h4F;
            4'h2:    g = 7'h12;
            4'h3:    g = 7'h06;
            4'h4:    g = 7'h4C;
            4'h5:    g = 7'h24;
            4'h6:    g = 7'h20;
            4'h7:    g = 7'h0F;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h04;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h60;
            4'hC:    g = 7'h31;
            4'hD:    g = 7'h42;
            4'hE:    g = 7'h30;
            4'hF:    g = 7'h38;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    logic [7:0]            ctrl_q,       ctrl_d;
    logic [7:0]            divisor_q,    divisor_d;
    logic [NUM_DIGITS-1:0] blank_q,      blank_d;
    logic [NUM_DIGITS-1:0] dp_q,         dp_d;
    logic [NUM_DIGITS-1:0] blink_q,      blink_d;
    logic [7:0]            blink_rate_q, blink_rate_d;
    logic [7:0]            digit_q [NUM_DIGITS];
    logic [7:0]            digit_d [NUM_DIGITS];
    logic [7:0]            rd_data_q,    rd_data_d;

    logic [SLOT_W-1:0]     slot_cnt_q,   slot_cnt_d;
    logic [IDX_W-1:0]      idx_q,        idx_d;
    logic [3:0]            pwm_cnt_q,    pwm_cnt_d;
    logic [7:0]            frame_cnt_q,  frame_cnt_d;
    logic                  blink_phase_q, blink_phase_d;

    logic [NUM_DIGITS-1:0] anode_q,      anode_d;
    logic [6:0]            seg_q,        seg_d;
    logic                  seg_dp_q,     seg_dp_d;

    logic                  wr_en_s, rd_en_s;
    logic [7:0]            rd_mux_s;
    logic                  enable_s, blink_en_s, raw_mode_s;
    logic [3:0]            brightness_s;
    logic [SLOT_W-1:0]     slot_last_s;
    logic [6:0]            cur_digit_s;
    logic                  cur_blank_s, cur_dp_s, cur_blink_s;
    logic                  lit_s;

    assign wr_en_s      = Cen & Wr;
    assign rd_en_s      = Cen & Rd;
    assign enable_s     = ctrl_q[0];
    assign blink_en_s   = ctrl_q[1];
    assign raw_mode_s   = ctrl_q[2];
    assign brightness_s = ctrl_q[7:4];
    // Wraps modulo 2^SLOT_W, so DIVISOR=255 still yields the all-ones terminal count.
    assign slot_last_s  = ((SLOT_W'(divisor_q) + SLOT_W'(1)) << PRESCALE_SHIFT) - SLOT_W'(1);

    // Register-file write decode
    always_comb begin
        ctrl_d       = ctrl_q;
        divisor_d    = divisor_q;
        blank_d      = blank_q;
        dp_d         = dp_q;
        blink_d      = blink_q;
        blink_rate_d = blink_rate_q;
        digit_d      = digit_q;
        if (wr_en_s) begin
            case (Address)
                4'h0:    ctrl_d       = Data_Bus_in;
                4'h1:    divisor_d    = Data_Bus_in;
                4'h2:    blank_d      = Data_Bus_in[NUM_DIGITS-1:0];
                4'h3:    dp_d         = Data_Bus_in[NUM_DIGITS-1:0];
                4'h4:    blink_d      = Data_Bus_in[NUM_DIGITS-1:0];
                4'h5:    blink_rate_d = Data_Bus_in;
                default: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (Address == 4'(8 + i)) begin
                            digit_d[i] = Data_Bus_in;
                        end else begin
                            digit_d[i] = digit_q[i];
                        end
                    end
                end
            endcase
        end else begin
            ctrl_d = ctrl_q;
        end
    end

    // Read mux and registered read data (pre-write values on a same-cycle write)
    always_comb begin
        rd_mux_s = 8'h00;
        case (Address)
            4'h0:    rd_mux_s = ctrl_q;
            4'h1:    rd_mux_s = divisor_q;
            4'h2:    rd_mux_s = 8'(blank_q);
            4'h3:    rd_mux_s = 8'(dp_q);
            4'h4:    rd_mux_s = 8'(blink_q);
            4'h5:    rd_mux_s = blink_rate_q;
            default: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (Address == 4'(8 + i)) begin
                        rd_mux_s = digit_q[i];
                    end else begin
                        rd_mux_s = rd_mux_s;
                    end
                end
            end
        endcase
        if (rd_en_s) begin
            rd_data_d = rd_mux_s;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Per-digit attributes of the digit currently being scanned
    always_comb begin
        cur_digit_s = 7'h00;
        cur_blank_s = 1'b0;
        cur_dp_s    = 1'b0;
        cur_blink_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit_s = digit_q[i][6:0];
                cur_blank_s = blank_q[i];
                cur_dp_s    = dp_q[i];
                cur_blink_s = blink_q[i];
            end else begin
                cur_digit_s = cur_digit_s;
            end
        end
    end

    // Scan, PWM and blink-frame sequencing
    always_comb begin
        slot_cnt_d    = '0;
        idx_d         = '0;
        pwm_cnt_d     = 4'h0;
        frame_cnt_d   = 8'h00;
        blink_phase_d = 1'b0;
        if (enable_s) begin
            pwm_cnt_d     = pwm_cnt_q + 4'h1;
            idx_d         = idx_q;
            frame_cnt_d   = frame_cnt_q;
            blink_phase_d = blink_phase_q;
            if (slot_cnt_q >= slot_last_s) begin
                slot_cnt_d = '0;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (frame_cnt_q == blink_rate_q) begin
                        frame_cnt_d   = 8'h00;
                        blink_phase_d = ~blink_phase_q;
                    end else begin
                        frame_cnt_d   = frame_cnt_q + 8'h01;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                slot_cnt_d = slot_cnt_q + SLOT_W'(1);
            end
        end else begin
            slot_cnt_d = '0;
        end
    end

    // Pin drive: anode and segments are computed together so they switch on the same edge
    always_comb begin
        lit_s = enable_s & ~cur_blank_s & ~(blink_en_s & cur_blink_s & blink_phase_q)
              & (pwm_cnt_q <= brightness_s);
        if (lit_s) begin
            anode_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d    = raw_mode_s ? ~cur_digit_s : hex_glyph(cur_digit_s[3:0]);
            seg_dp_d = ~cur_dp_s;
        end else begin
            anode_d  = '1;
            seg_d    = 7'h7F;
            seg_dp_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q        <= 8'h00;
            divisor_q     <= 8'h00;
            blank_q       <= '0;
            dp_q          <= '0;
            blink_q       <= '0;
            blink_rate_q  <= 8'h00;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= 8'h00;
            end
            rd_data_q     <= 8'h00;
            slot_cnt_q    <= '0;
            idx_q         <= '0;
            pwm_cnt_q     <= 4'h0;
            frame_cnt_q   <= 8'h00;
            blink_phase_q <= 1'b0;
            anode_q       <= '1;
            seg_q         <= 7'h7F;
            seg_dp_q      <= 1'b1;
        end else begin
            ctrl_q        <= ctrl_d;
            divisor_q     <= divisor_d;
            blank_q       <= blank_d;
            dp_q          <= dp_d;
            blink_q       <= blink_d;
            blink_rate_q  <= blink_rate_d;
            digit_q       <= digit_d;
            rd_data_q     <= rd_data_d;
            slot_cnt_q    <= slot_cnt_d;
            idx_q         <= idx_d;
            pwm_cnt_q     <= pwm_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            anode_q       <= anode_d;
            seg_q         <= seg_d;
            seg_dp_q      <= seg_dp_d;
        end
    end

    assign Data_Bus_out = rd_data_q;
    assign anode        = anode_q;
    assign seg          = seg_q;
    assign seg_dp       = seg_dp_q;

endmodule

// File: tb/tb_seg_display_scan_ctrl.sv
// Directed self-checking bench for seg_display_scan_ctrl with PRESCALE_SHIFT=2, 4 digits.
module tb_seg_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] Address = 4'h0;
    logic [7:0] Data_Bus_in = 8'h00;
    logic [7:0] Data_Bus_out;
    logic       Cen = 1'b0;
    logic       Rd = 1'b0;
    logic       Wr = 1'b0;
    logic [6:0] seg;
    logic       seg_dp;
    logic [3:0] anode;

    int errors = 0;
    int checks = 0;

    logic [6:0] glyph_tab [4];
    logic [3:0] raw_an    [4];
    logic [6:0] raw_seg   [4];
    logic       raw_dp    [4];
    logic [3:0] exp_an;

    seg_display_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE_SHIFT(2)) dut (
        .clk(clk), .rst(rst), .Address(Address), .Data_Bus_in(Data_Bus_in),
        .Data_Bus_out(Data_Bus_out), .Cen(Cen), .Rd(Rd), .Wr(Wr),
        .seg(seg), .seg_dp(seg_dp), .anode(anode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        Address = a; Data_Bus_in = d; Cen = 1'b1; Wr = 1'b1;
        @(posedge clk); #1;
        Cen = 1'b0; Wr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        Address = a; Cen = 1'b1; Rd = 1'b1;
        @(posedge clk); #1;
        Cen = 1'b0; Rd = 1'b0;
        chk(tag, Data_Bus_out, exp);
    endtask

    initial begin
        glyph_tab = '{7'h4F, 7'h12, 7'h06, 7'h4C};
        raw_an    = '{4'hE, 4'hF, 4'hB, 4'h7};
        raw_seg   = '{7'h00, 7'h7F, 7'h43, 7'h7B};
        raw_dp    = '{1'b0, 1'b1, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_anode", {4'h0, anode}, 8'h0F);
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_dp", {7'h00, seg_dp}, 8'h01);
        chk("rst_dbo", Data_Bus_out, 8'h00);
        rd_chk("rst_ctrl", 4'h0, 8'h00);

        // Basic scan: 8-clock slots, brightness 15
        wr(4'h1, 8'h01);
        wr(4'h8, 8'h01); wr(4'h9, 8'h02); wr(4'hA, 8'h03); wr(4'hB, 8'h04);
        wr(4'h0, 8'hF1);
        chk("scan_dark0", {4'h0, anode}, 8'h0F);
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            exp_an = 4'hF ^ (4'b0001 << (((k - 1) / 8) % 4));
            chk("scan_anode", {4'h0, anode}, {4'h0, exp_an});
            chk("scan_seg", {1'b0, seg}, {1'b0, glyph_tab[((k - 1) / 8) % 4]});
        end

        // Register access
        wr(4'h1, 8'hA5);
        wr(4'hA, 8'h3C);
        rd_chk("rd_div", 4'h1, 8'hA5);
        rd_chk("rd_dig2", 4'hA, 8'h3C);
        rd_chk("rd_unmapped7", 4'h7, 8'h00);
        wr(4'hC, 8'h55);
        rd_chk("rd_dig4_absent", 4'hC, 8'h00);
        wr(4'h2, 8'hFF);
        rd_chk("rd_blank_mask", 4'h2, 8'h0F);
        wr(4'h2, 8'h00);
        wr(4'h5, 8'h11);
        Address = 4'h5; Data_Bus_in = 8'h22; Cen = 1'b1; Rd = 1'b1; Wr = 1'b1;
        @(posedge clk); #1;
        Cen = 1'b0; Rd = 1'b0; Wr = 1'b0;
        chk("rdwr_old", Data_Bus_out, 8'h11);
        rd_chk("rdwr_new", 4'h5, 8'h22);
        @(posedge clk); #1;
        chk("dbo_hold", Data_Bus_out, 8'h22);

        // Brightness 3: lit while pwm_cnt 0..3 within a 32-clock slot
        wr(4'h0, 8'h00);
        wr(4'h1, 8'h07);
        wr(4'h0, 8'h31);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            if (((k - 1) % 16) <= 3) begin
                chk("pwm_anode_on", {4'h0, anode}, 8'h0E);
                chk("pwm_seg_on", {1'b0, seg}, 8'h4F);
            end else begin
                chk("pwm_anode_off", {4'h0, anode}, 8'h0F);
                chk("pwm_seg_off", {1'b0, seg}, 8'h7F);
            end
        end

        // Blank, DP and raw mode
        wr(4'h0, 8'h00);
        wr(4'h1, 8'h01);
        wr(4'h2, 8'h02);
        wr(4'h3, 8'h01);
        wr(4'h8, 8'h7F);
        wr(4'h0, 8'hF5);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            chk("raw_anode", {4'h0, anode}, {4'h0, raw_an[((k - 1) / 8) % 4]});
            chk("raw_seg", {1'b0, seg}, {1'b0, raw_seg[((k - 1) / 8) % 4]});
            chk("raw_dp", {7'h00, seg_dp}, {7'h00, raw_dp[((k - 1) / 8) % 4]});
        end

        // Blink digit 0: two frames lit, two frames dark (frame = 16 clocks)
        wr(4'h0, 8'h00);
        wr(4'h1, 8'h00);
        wr(4'h2, 8'h00);
        wr(4'h3, 8'h00);
        wr(4'h4, 8'h01);
        wr(4'h5, 8'h01);
        wr(4'h0, 8'hF3);
        for (int k = 1; k <= 96; k++) begin
            @(posedge clk); #1;
            if (((((k - 1) / 4) % 4) == 0) && ((((k - 1) / 32) % 2) == 1)) begin
                exp_an = 4'hF;
            end else begin
                exp_an = 4'hF ^ (4'b0001 << (((k - 1) / 4) % 4));
            end
            chk("blink_anode", {4'h0, anode}, {4'h0, exp_an});
        end

        // Lowering DIVISOR mid-slot ends the slot on the next clock
        wr(4'h0, 8'h00);
        wr(4'h4, 8'h00);
        wr(4'h1, 8'h07);
        wr(4'h0, 8'hF1);
        repeat (10) @(posedge clk);
        #1 chk("div_pre", {4'h0, anode}, 8'h0E);
        wr(4'h1, 8'h00);
        chk("div_wr_edge", {4'h0, anode}, 8'h0E);
        @(posedge clk); #1;
        chk("div_slot_end", {4'h0, anode}, 8'h0E);
        @(posedge clk); #1;
        chk("div_next_digit", {4'h0, anode}, 8'h0D);
        repeat (4) @(posedge clk);
        #1 chk("div_short_slot", {4'h0, anode}, 8'h0B);

        // Asynchronous reset mid-scan
        #2 rst = 1'b1;
        #1;
        chk("arst_anode", {4'h0, anode}, 8'h0F);
        chk("arst_seg", {1'b0, seg}, 8'h7F);
        chk("arst_dp", {7'h00, seg_dp}, 8'h01);
        @(negedge clk);
        rst = 1'b0;
        chk("arst_dbo", Data_Bus_out, 8'h00);
        rd_chk("arst_ctrl", 4'h0, 8'h00);
        rd_chk("arst_div", 4'h1, 8'h00);
        @(posedge clk); #1;
        chk("arst_stay_dark", {4'h0, anode}, 8'h0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_display_scan_ctrl.md
Name: seg_display_scan_ctrl

Overview:
- Bus-mapped, time-multiplexed N-digit 7-segment display controller; successor to the fixed 4-digit Basys3 display peripheral.
- Sits on the 8-bit CPU peripheral bus and drives common-anode digit/segment pins directly.
- Adds over the previous generation:
  - parametrised digit count;
  - prescaled scan timing;
  - per-digit blank and decimal-point masks;
  - raw-segment mode;
  - 16-level PWM brightness;
  - per-digit hardware blink.

Parameters:
- NUM_DIGITS, 4, number of digits/anodes scanned; legal range 1..8.
- PRESCALE_SHIFT, 8, log2 of clocks per DIVISOR step.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- Address  input  4  register address.
- Data_Bus_in  input  8  write data.
- Data_Bus_out  output  8  registered read data.
- Cen  input  1  chip enable; qualifies Rd and Wr.
- Rd  input  1  read strobe.
- Wr  input  1  write strobe.
- seg  output  7  segments, active-low; seg[6]=A through seg[0]=G.
- seg_dp  output  1  decimal point, active-low.
- anode  output  NUM_DIGITS  digit enables, active-low; anode[i] selects digit i.

Behaviour:
- Reset is asynchronous and active-high; all state is clocked on posedge clk.
- Register map (8-bit):
  - 0x0 CTRL: [0] enable, [1] blink_en, [2] raw_mode, [7:4] brightness.
  - 0x1 DIVISOR.
  - 0x2 BLANK mask.
  - 0x3 DP mask.
  - 0x4 BLINK mask.
  - 0x5 BLINK_RATE.
  - 0x8+i DIGIT[i], for i < NUM_DIGITS.
- Mask bits at or above NUM_DIGITS read back 0; writes to them are ignored.
- Write: on posedge clk when Cen&Wr, the addressed register takes Data_Bus_in. Unmapped addresses are ignored.
- Read: when Cen&Rd, Data_Bus_out <= addressed register on the next posedge (1-cycle latency). Unmapped addresses return 0x00. Otherwise Data_Bus_out holds its value.
- Simultaneous read and write to the same address: the read returns the pre-write value.
- Reset values:
  - all registers 0x00; Data_Bus_out 0x00;
  - anode all 1s, seg 7'h7F, seg_dp 1;
  - digit index 0; slot counter, PWM counter, frame counter and blink_phase all 0.
- Slot timing: slot period P = (DIVISOR+1) << PRESCALE_SHIFT clocks.
  - Slot counter counts 0..P-1.
  - When slot_cnt >= P-1, slot_cnt <= 0 and the digit index advances, wrapping NUM_DIGITS-1 -> 0.
  - The >= compare makes a DIVISOR reduction mid-slot end that slot on the next cycle; there is no lock-up.
- Frame/blink: on each digit index wrap to 0:
  - if frame_cnt == BLINK_RATE, then frame_cnt <= 0 and blink_phase toggles;
  - else frame_cnt increments.
  - BLINK_RATE=0 toggles blink_phase every frame.
- PWM: a 4-bit pwm_cnt free-runs every clock while enabled. The lit condition requires pwm_cnt <= brightness, so brightness 15 gives 100% duty and 0 gives 1/16 duty.
- Digit i = current index is lit when all of the following hold:
  - enable = 1;
  - BLANK[i] = 0;
  - !(blink_en & BLINK[i] & blink_phase);
  - the PWM condition is true.
- When lit, anode[i] = 0 and every other anode bit = 1. When not lit, all anode bits = 1.
- Segments:
  - raw_mode = 0: the standard hex 0-F glyph of DIGIT[i][3:0], active-low. Glyphs are 0:7'h01, 1:7'h4F, 2:7'h12, 3:7'h06, 4:7'h4C, 5:7'h24, 6:7'h20, 7:7'h0F, 8:7'h00, 9:7'h04, A:7'h08, b:7'h60, C:7'h31, d:7'h42, E:7'h30, F:7'h38.
  - raw_mode = 1: seg = ~DIGIT[i][6:0].
  - seg_dp = ~DP[i].
  - When the digit is not lit, seg = 7'h7F and seg_dp = 1.
- anode, seg and seg_dp are registered: they reflect the index/counter state of the previous cycle (1-cycle output latency). The anode bit change and the seg change land on the same edge, so there is no ghosting.
- enable = 0:
  - slot, PWM and frame counters, digit index and blink_phase are held at 0;
  - outputs go dark on the next edge.
  - Re-enabling starts at digit 0, slot_cnt 0.
- Reset asserted mid-scan immediately forces all outputs dark and all state to reset values, independent of clk.

Test Plan:
- Reset while scanning with enable=1 -> anode, seg and seg_dp go to all 1s asynchronously, before the next clk edge. After release, a read of 0x0 returns 0x00 and Data_Bus_out = 0x00.
- PRESCALE_SHIFT=2, DIVISOR=1, CTRL=0xF1, DIGIT0..3=0x1,0x2,0x3,0x4:
  - each anode low for exactly 8 clocks, in order anode=1110,1101,1011,0111, then repeat;
  - seg = 7'h4F, 7'h12, 7'h06, 7'h4C respectively, one cycle after index change.
- Write then read DIVISOR=0xA5 and DIGIT2=0x3C -> reads return 0xA5 and 0x3C one cycle after the Rd edge.
  - Read of 0x7 returns 0x00.
  - Same-cycle Rd+Wr of 0x5 returns the old value.
- Brightness: CTRL=0x31 -> within a slot the active anode is low 4 of every 16 clocks (pwm_cnt 0..3); seg is 7'h7F when the anode is high.
- BLANK=0x2, DP=0x1, raw_mode with DIGIT0=0x7F -> digit 1 never lit; digit 0 shows seg=7'h00 and seg_dp=0.
- Blink: blink_en=1, BLINK=0x1, BLINK_RATE=1 -> digit 0 is lit for 2 frames, dark for 2 frames, and so on; other digits are unaffected. Lowering DIVISOR mid-slot ends the slot on the next clock.
